hsx2rgb_pipe: RTL and testbench

HSX2RGB_PIPE -- requirements
Module: hsx2rgb_pipe

---
 rtl/hsx_pkg.sv | 31 +++
 rtl/ufp_mult_w.sv | 16 +
 rtl/hsx2rgb_pipe.sv | 197 +++++++++++++++++++
 tb/tb_hsx2rgb_pipe.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsx_pkg.sv
// Shared definitions for the HSL/HSV to RGB colour converter:
// colour-model select, hue sector encoding and a saturating adder.
package hsx_pkg;

  localparam logic MODE_HSL = 1'b0;
  localparam logic MODE_HSV = 1'b1;

  localparam int STAGES = 4;

  // One sector per 60 degrees of hue, named by the primaries it spans
  typedef enum logic [2:0] {
    SEC_RY = 3'd0,
    SEC_YG = 3'd1,
    SEC_GC = 3'd2,
    SEC_CB = 3'd3,
    SEC_BM = 3'd4,
    SEC_MR = 3'd5
  } sector_e;

  // a + b clamped to 2^w-1; callers cast the result down to their width
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/ufp_mult_w.sv
// Unsigned fixed-point multiply p = (a*b) >> W, purely combinational.
// a carries one extra bit so that unity (2^W) itself can be an operand.
module ufp_mult_w #(
  parameter int W = 10
) (
  input  logic [W:0]   a,
  input  logic [W-1:0] b,
  output logic [W:0]   p
);

  logic [2*W:0] prod;

  assign prod = {{W{1'b0}}, a} * {{(W+1){1'b0}}, b};
  assign p    = prod[2*W:W];

endmodule

// File: rtl/hsx2rgb_pipe.sv
// Four-stage HSL/HSV to RGB converter with valid/ready handshake.
// The whole pipe freezes while the output is valid and not taken.
module hsx2rgb_pipe
  import hsx_pkg::*;
#(
  parameter int W          = 10,
  parameter int USER_W     = 2,
  parameter int SAT_THRESH = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              iValid,
  output logic              oReady,
  input  logic [W-1:0]      iHue,
  input  logic [W-1:0]      iSat,
  input  logic [W-1:0]      iLum,
  input  logic              iMode,
  input  logic [USER_W-1:0] iUser,
  output logic              oValid,
  input  logic              iReady,
  output logic [W-1:0]      oRed,
  output logic [W-1:0]      oGreen,
  output logic [W-1:0]      oBlue,
  output logic [USER_W-1:0] oUser
);

  localparam logic [W:0]   UNITY = {1'b1, {W{1'b0}}};
  localparam logic [W-1:0] THR   = W'(SAT_THRESH);

  typedef struct packed {
    sector_e           k;
    logic [W-1:0]      f;
    logic [W:0]        d;
    logic [W-1:0]      sat;
    logic [W-1:0]      lum;
    logic              mode;
    logic              achro;
    logic [USER_W-1:0] user;
  } s1_t;

  typedef struct packed {
    sector_e           k;
    logic [W-1:0]      f;
    logic [W:0]        c;
    logic [W-1:0]      lum;
    logic              mode;
    logic              achro;
    logic [USER_W-1:0] user;
  } s2_t;

  typedef struct packed {
    sector_e           k;
    logic [W:0]        c;
    logic [W:0]        rise;
    logic [W:0]        fall;
    logic [W:0]        m;
    logic [W-1:0]      lum;
    logic              achro;
    logic [USER_W-1:0] user;
  } s3_t;

  typedef struct packed {
    logic [W-1:0]      r;
    logic [W-1:0]      g;
    logic [W-1:0]      b;
    logic [USER_W-1:0] user;
  } s4_t;

  s1_t s1_q, s1_n;
  s2_t s2_q, s2_n;
  s3_t s3_q, s3_n;
  s4_t s4_q, s4_n;

  logic [STAGES:1] vld_pipe;
  logic            stall;

  assign stall  = oValid & ~iReady;
  assign oReady = ~stall;
  assign oValid = vld_pipe[STAGES];

  // Stage 1: hue sector/fraction and lightness distance from mid-grey
  logic [W+2:0] h6;
  logic [W:0]   lum2;

  assign h6   = ({3'b000, iHue} << 2) + ({3'b000, iHue} << 1);
  assign lum2 = {iLum, 1'b0};

  always_comb begin
    s1_n       = '0;
    s1_n.k     = sector_e'(h6[W+2:W]);
    s1_n.f     = h6[W-1:0];
    s1_n.d     = (lum2 >= UNITY) ? (lum2 - UNITY) : (UNITY - lum2);
    s1_n.sat   = iSat;
    s1_n.lum   = iLum;
    s1_n.mode  = iMode;
    s1_n.achro = (iSat < THR);
    s1_n.user  = iUser;
  end

  // Stage 2: chroma
  logic [W:0] mul2_a, mul2_p;

  assign mul2_a = (s1_q.mode == MODE_HSL) ? (UNITY - s1_q.d) : {1'b0, s1_q.lum};

  ufp_mult_w #(.W(W)) u_mul_chroma (
    .a (mul2_a),
    .b (s1_q.sat),
    .p (mul2_p)
  );

  always_comb begin
    s2_n       = '0;
    s2_n.k     = s1_q.k;
    s2_n.f     = s1_q.f;
    s2_n.c     = mul2_p;
    s2_n.lum   = s1_q.lum;
    s2_n.mode  = s1_q.mode;
    s2_n.achro = s1_q.achro;
    s2_n.user  = s1_q.user;
  end

  // Stage 3: rising/falling ramps within the sector, and the grey offset m
  logic [W:0] rise3;

  ufp_mult_w #(.W(W)) u_mul_ramp (
    .a (s2_q.c),
    .b (s2_q.f),
    .p (rise3)
  );

  always_comb begin
    s3_n       = '0;
    s3_n.k     = s2_q.k;
    s3_n.c     = s2_q.c;
    s3_n.rise  = rise3;
    s3_n.fall  = s2_q.c - rise3;
    s3_n.m     = (s2_q.mode == MODE_HSL) ? ({1'b0, s2_q.lum} - (s2_q.c >> 1))
                                         : ({1'b0, s2_q.lum} - s2_q.c);
    s3_n.lum   = s2_q.lum;
    s3_n.achro = s2_q.achro;
    s3_n.user  = s2_q.user;
  end

  // Stage 4: sector select and saturating offset add
  logic [W:0] tr, tg, tb;

  always_comb begin
    tr = '0;
    tg = '0;
    tb = '0;
    unique case (s3_q.k)
      SEC_RY: begin tr = s3_q.c;    tg = s3_q.rise; end
      SEC_YG: begin tr = s3_q.fall; tg = s3_q.c;    end
      SEC_GC: begin tg = s3_q.c;    tb = s3_q.rise; end
      SEC_CB: begin tg = s3_q.fall; tb = s3_q.c;    end
      SEC_BM: begin tr = s3_q.rise; tb = s3_q.c;    end
      SEC_MR: begin tr = s3_q.c;    tb = s3_q.fall; end
      default: ;
    endcase
  end

  always_comb begin
    s4_n      = '0;
    s4_n.user = s3_q.user;
    if (s3_q.achro) begin
      s4_n.r = s3_q.lum;
      s4_n.g = s3_q.lum;
      s4_n.b = s3_q.lum;
    end else begin
      s4_n.r = W'(sat_add(32'(s3_q.m), 32'(tr), W));
      s4_n.g = W'(sat_add(32'(s3_q.m), 32'(tg), W));
      s4_n.b = W'(sat_add(32'(s3_q.m), 32'(tb), W));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      s4_q     <= '0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], iValid};
      s1_q     <= s1_n;
      s2_q     <= s2_n;
      s3_q     <= s3_n;
      s4_q     <= s4_n;
    end
  end

  assign oRed   = s4_q.r;
  assign oGreen = s4_q.g;
  assign oBlue  = s4_q.b;
  assign oUser  = s4_q.user;

endmodule

// File: tb/tb_hsx2rgb_pipe.sv
// Randomised bench for hsx2rgb_pipe: a scoreboard of reference-model
// results, plus directed latency, stall, reset and mode-alternation cases.
module tb_hsx2rgb_pipe;

  localparam int W  = 10;
  localparam int UW = 2;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          iValid  = 1'b0;
  logic          oReady;
  logic [W-1:0]  iHue = '0, iSat = '0, iLum = '0;
  logic          iMode = 1'b0;
  logic [UW-1:0] iUser = '0;
  logic          oValid;
  logic          iReady = 1'b1;
  logic [W-1:0]  oRed, oGreen, oBlue;
  logic [UW-1:0] oUser;

  always #5 clock = ~clock;

  hsx2rgb_pipe #(.W(W), .USER_W(UW), .SAT_THRESH(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .iValid  (iValid),
    .oReady  (oReady),
    .iHue    (iHue),
    .iSat    (iSat),
    .iLum    (iLum),
    .iMode   (iMode),
    .iUser   (iUser),
    .oValid  (oValid),
    .iReady  (iReady),
    .oRed    (oRed),
    .oGreen  (oGreen),
    .oBlue   (oBlue),
    .oUser   (oUser)
  );

  typedef struct {
    int r;
    int g;
    int b;
    int u;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   nchk = 0, nerr = 0, cyc = 0;
  int   stall_lo = 0, stall_hi = 0, stall_seen = 0;
  bit   rdy_rand = 1'b0;
  bit   was_stall = 1'b0;
  int   hr, hg, hb, hu;

  task automatic check(input string tag, input int obs, input int exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > 1023) ? 1023 : v;
  endfunction

  // Colour conversion straight from the defining equations (W=10, unity=1024)
  function automatic exp_t model(input int h, input int s, input int l,
                                 input int mode, input int u);
    exp_t x;
    int h6, k, f, d, c, m, rise, fall, tr, tg, tb;
    x.u = u;
    if (s < 16) begin
      x.r = l; x.g = l; x.b = l;
      return x;
    end
    h6 = h * 6;
    k  = h6 / 1024;
    f  = h6 % 1024;
    if (mode == 0) begin
      d = (2 * l > 1024) ? 2 * l - 1024 : 1024 - 2 * l;
      c = ((1024 - d) * s) / 1024;
      m = l - c / 2;
    end else begin
      c = (l * s) / 1024;
      m = l - c;
    end
    rise = (c * f) / 1024;
    fall = c - rise;
    tr = 0; tg = 0; tb = 0;
    case (k)
      0: begin tr = c;    tg = rise; end
      1: begin tr = fall; tg = c;    end
      2: begin tg = c;    tb = rise; end
      3: begin tg = fall; tb = c;    end
      4: begin tr = rise; tb = c;    end
      default: begin tr = c; tb = fall; end
    endcase
    x.r = clamp(m + tr);
    x.g = clamp(m + tg);
    x.b = clamp(m + tb);
    return x;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    if (rdy_rand) iReady = ($urandom_range(0, 3) != 0);
    else          iReady = !(cyc >= stall_lo && cyc < stall_hi);
  end

  // Monitor: transfers are decided by the levels seen here, mid-cycle
  always @(negedge clock) begin
    if (!reset_n) begin
      was_stall = 1'b0;
    end else begin
      if (iValid && oReady)
        sb.push_back(model(int'(iHue), int'(iSat), int'(iLum), int'(iMode), int'(iUser)));
      if (oValid) begin
        if (was_stall) begin
          check("frz_red",   int'(oRed),   hr);
          check("frz_green", int'(oGreen), hg);
          check("frz_blue",  int'(oBlue),  hb);
          check("frz_user",  int'(oUser),  hu);
        end
        if (!iReady) begin
          check("ordy_stall", int'(oReady), 0);
          stall_seen++;
          hr = int'(oRed); hg = int'(oGreen); hb = int'(oBlue); hu = int'(oUser);
          was_stall = 1'b1;
        end else begin
          was_stall = 1'b0;
          if (sb.size() == 0) begin
            check("spurious_out", int'(oValid), 0);
          end else begin
            e = sb.pop_front();
            check("red",   int'(oRed),   e.r);
            check("green", int'(oGreen), e.g);
            check("blue",  int'(oBlue),  e.b);
            check("user",  int'(oUser),  e.u);
          end
        end
      end else begin
        was_stall = 1'b0;
      end
    end
  end

  task automatic send(input int h, input int s, input int l, input int m, input int u);
    bit acc;
    int n;
    iValid = 1'b1;
    iHue   = W'(h);
    iSat   = W'(s);
    iLum   = W'(l);
    iMode  = 1'(m);
    iUser  = UW'(u);
    n = 0;
    do begin
      @(negedge clock);
      acc = oReady;
      @(posedge clock);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("accept_timeout", int'(acc), 1);
    iValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  function automatic int pick_hue();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 0;
    if (r == 1) return 1023;
    return $urandom_range(0, 1023);
  endfunction

  function automatic int pick_sat();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 15;
    if (r == 1) return 16;
    if (r == 2) return 1023;
    if (r == 3) return 0;
    return $urandom_range(0, 1023);
  endfunction

  function automatic int pick_lum();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 0;
    if (r == 1) return 1023;
    if (r == 2) return 512;
    return $urandom_range(0, 1023);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ovalid", int'(oValid), 0);
    check("rst_oready", int'(oReady), 1);
    check("rst_red",    int'(oRed),   0);
    check("rst_green",  int'(oGreen), 0);
    check("rst_blue",   int'(oBlue),  0);
    check("rst_user",   int'(oUser),  0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Saturated red at mid lightness; also measures accept-to-valid latency
    send(0, 1023, 512, 0, 1);
    lat = 1;
    while (!oValid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check("latency", lat, 4);
    drain();

    // HSV hue 341 lands in sector 1 with f=1022; (1023*1023)>>10 gives C=1022
    send(341, 1023, 1023, 1, 2);
    send(77, 10, 300, 0, 3);
    send(900, 10, 300, 1, 0);
    send(500, 15, 700, 0, 1);
    send(500, 16, 700, 0, 2);
    send(1023, 1023, 0, 0, 3);
    send(1023, 1023, 1023, 0, 0);
    send(170, 1023, 1023, 1, 1);
    send(683, 600, 256, 0, 2);
    drain();

    // Six back-to-back pixels with the sink stalling for three cycles
    stall_lo = cyc + 5;
    stall_hi = cyc + 8;
    for (int i = 0; i < 6; i++) send(100 + i * 150, 900, 400 + i * 50, i % 2, i % 4);
    drain();
    check("stall_seen", int'(stall_seen > 0), 1);

    // Reset with three pixels in flight
    for (int i = 0; i < 3; i++) send(200 * i, 800, 600, 0, i);
    #2;
    reset_n = 1'b0;
    #1;
    check("inflight_rst_ovalid", int'(oValid), 0);
    check("inflight_rst_oready", int'(oReady), 1);
    check("inflight_rst_red",    int'(oRed),   0);
    sb.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clock);
      check("post_rst_idle", int'(oValid), 0);
    end
    @(posedge clock);
    #1;

    // Alternating colour model per pixel, sideband counting 0..3
    for (int i = 0; i < 8; i++)
      send($urandom_range(0, 1023), $urandom_range(16, 1023), $urandom_range(0, 1023), i % 2, i % 4);
    drain();

    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
      send(pick_hue(), pick_sat(), pick_lum(), $urandom_range(0, 1), $urandom_range(0, 3));
    end
    rdy_rand = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
